// File: rtl/npc_seq_if.sv
// Sequencer-side bundle: fetch port, decoder hookup, execute/memory strobes and debug status.
// The master modport is the sequencer; the slave modport is the surrounding core or a testbench.
interface npc_seq_if;
  logic        ifu_req;
  logic [31:0] ifu_addr;
  logic        ifu_valid;
  logic [31:0] ifu_rdata;
  logic [31:0] inst;
  logic [6:0]  opcode;
  logic [31:0] next_pc;
  logic [31:0] pc;
  logic        lsu_req;
  logic        lsu_done;
  logic        rf_we;
  logic        inst_commit;
  logic        halted;
  logic [1:0]  halt_code;
  logic [2:0]  state;

  modport master (
    output ifu_req, ifu_addr, inst, pc, lsu_req, rf_we, inst_commit, halted, halt_code, state,
    input  ifu_valid, ifu_rdata, opcode, next_pc, lsu_done
  );

  modport slave (
    input  ifu_req, ifu_addr, inst, pc, lsu_req, rf_we, inst_commit, halted, halt_code, state,
    output ifu_valid, ifu_rdata, opcode, next_pc, lsu_done
  );
endinterface

// File: rtl/npc_seq.sv
// Multi-cycle NPC control sequencer: FETCH/DECODE/EXEC/[MEM]/WB, 4 cycles for ALU ops, 5+ for load/store.
// Stalls in FETCH until ifu_valid (bounded by a timeout) and in MEM until lsu_done; all outputs are Moore.
module npc_seq #(
  parameter logic [31:0] RESET_PC = 32'h8000_0000,
  parameter int unsigned TO_W     = 8
) (
  input  logic      clk,
  input  logic      rst,
  npc_seq_if.master bus
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_DECODE = 3'd2,
    S_EXEC   = 3'd3,
    S_MEM    = 3'd4,
    S_WB     = 3'd5,
    S_HALT   = 3'd6
  } state_e;

  localparam logic [6:0]  OP_LUI    = 7'b0110111;
  localparam logic [6:0]  OP_AUIPC  = 7'b0010111;
  localparam logic [6:0]  OP_JAL    = 7'b1101111;
  localparam logic [6:0]  OP_JALR   = 7'b1100111;
  localparam logic [6:0]  OP_BRANCH = 7'b1100011;
  localparam logic [6:0]  OP_LOAD   = 7'b0000011;
  localparam logic [6:0]  OP_STORE  = 7'b0100011;
  localparam logic [6:0]  OP_IMM    = 7'b0010011;
  localparam logic [6:0]  OP_OP     = 7'b0110011;
  localparam logic [6:0]  OP_SYSTEM = 7'b1110011;
  localparam logic [31:0] EBREAK    = 32'h0010_0073;
  localparam logic [31:0] NOP       = 32'h0000_0013;

  localparam logic [1:0] HC_EBREAK  = 2'd0;
  localparam logic [1:0] HC_ILLEGAL = 2'd1;
  localparam logic [1:0] HC_TIMEOUT = 2'd2;

  // The counter holds the number of idle FETCH cycles already seen, so the
  // timeout fires on the cycle whose increment would land on 2^TO_W-1.
  localparam logic [TO_W-1:0] TO_PRE = TO_W'((1 << TO_W) - 2);

  state_e          state_q, state_d;
  logic [31:0]     pc_q, pc_d;
  logic [31:0]     ir_q, ir_d;
  logic [TO_W-1:0] cnt_q, cnt_d;
  logic [1:0]      code_q, code_d;
  logic            mem_q, mem_d;
  logic            nowb_q, nowb_d;

  logic            op_legal;
  logic            op_mem;
  logic            op_nowb;

  always_comb begin
    op_legal = 1'b0;
    op_mem   = 1'b0;
    op_nowb  = 1'b0;
    unique case (bus.opcode)
      OP_LUI, OP_AUIPC, OP_JAL, OP_JALR, OP_IMM, OP_OP: op_legal = 1'b1;
      OP_BRANCH: begin
        op_legal = 1'b1;
        op_nowb  = 1'b1;
      end
      OP_LOAD: begin
        op_legal = 1'b1;
        op_mem   = 1'b1;
      end
      OP_STORE: begin
        op_legal = 1'b1;
        op_mem   = 1'b1;
        op_nowb  = 1'b1;
      end
      default: op_legal = 1'b0;
    endcase
  end

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    ir_d    = ir_q;
    cnt_d   = cnt_q;
    code_d  = code_q;
    mem_d   = mem_q;
    nowb_d  = nowb_q;
    unique case (state_q)
      S_IDLE: begin
        state_d = S_FETCH;
        cnt_d   = '0;
      end
      S_FETCH: begin
        if (bus.ifu_valid) begin
          ir_d    = bus.ifu_rdata;
          state_d = S_DECODE;
        end else if (cnt_q == TO_PRE) begin
          code_d  = HC_TIMEOUT;
          state_d = S_HALT;
        end else begin
          cnt_d = cnt_q + TO_W'(1);
        end
      end
      S_DECODE: begin
        if (op_legal) begin
          mem_d   = op_mem;
          nowb_d  = op_nowb;
          state_d = S_EXEC;
        end else if (bus.opcode == OP_SYSTEM && ir_q == EBREAK) begin
          code_d  = HC_EBREAK;
          state_d = S_HALT;
        end else begin
          code_d  = HC_ILLEGAL;
          state_d = S_HALT;
        end
      end
      S_EXEC: state_d = mem_q ? S_MEM : S_WB;
      S_MEM: begin
        if (bus.lsu_done) state_d = S_WB;
      end
      S_WB: begin
        pc_d    = bus.next_pc;
        cnt_d   = '0;
        state_d = S_FETCH;
      end
      S_HALT: state_d = S_HALT;
      default: state_d = S_HALT;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      pc_q    <= RESET_PC;
      ir_q    <= NOP;
      cnt_q   <= '0;
      code_q  <= HC_EBREAK;
      mem_q   <= 1'b0;
      nowb_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      ir_q    <= ir_d;
      cnt_q   <= cnt_d;
      code_q  <= code_d;
      mem_q   <= mem_d;
      nowb_q  <= nowb_d;
    end
  end

  assign bus.ifu_req     = (state_q == S_FETCH);
  assign bus.ifu_addr    = pc_q;
  assign bus.pc          = pc_q;
  assign bus.inst        = ir_q;
  assign bus.lsu_req     = (state_q == S_MEM);
  assign bus.rf_we       = (state_q == S_WB) && !nowb_q;
  assign bus.inst_commit = (state_q == S_WB);
  assign bus.halted      = (state_q == S_HALT);
  assign bus.halt_code   = code_q;
  assign bus.state       = state_q;

endmodule
